// File: rtl/i2s_frame_packer.sv
// i2s_frame_packer: multi-line I2S capture and frame packer, single clock (usbclk).
// Oversamples BCLK/WCLK/DIN, deserialises each half-frame into WIDTH-bit words,
// latches a full stereo frame, then emits the enabled slots as {frame, slot, word}
// through a show-ahead word FIFO to a valid/ready consumer.
// Ports:
//   usbclk, rst_n          clock, asynchronous active-low reset
//   i2s_bclk/wclk/din      asynchronous I2S inputs (wclk low = left)
//   slot_en                per-slot enable, bit 2c = ch c left, 2c+1 = ch c right
//   err_clr                pulse clearing the sticky overflow/frame_err flags
//   out_data/chan/frame    head-of-FIFO word, slot index and frame ID
//   out_valid/out_ready    consumer handshake
//   fifo_level             words held in the FIFO
//   overflow, frame_err    sticky: word dropped on full FIFO / short half-frame
module i2s_frame_packer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                      usbclk,
    input  logic                      rst_n,
    input  logic                      i2s_bclk,
    input  logic                      i2s_wclk,
    input  logic [CHANNELS-1:0]       i2s_din,
    input  logic [2*CHANNELS-1:0]     slot_en,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          out_data,
    output logic [3:0]                out_chan,
    output logic [7:0]                out_frame,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      frame_err
);
    localparam int unsigned Slots = 2 * CHANNELS;
    localparam int unsigned SlotW = $clog2(Slots);
    localparam int unsigned KW    = $clog2(WIDTH + 2);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned EntW  = 8 + 4 + WIDTH;

    localparam logic [KW-1:0]    KFull    = KW'(WIDTH);
    localparam logic [KW-1:0]    KSat     = KW'(WIDTH + 1);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(Slots - 1);
    localparam logic [LvlW-1:0]  DepthLvl = LvlW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StPack} state_e;

    // ---------------- input synchronisers ----------------
    logic                bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic                wclk_s1_q, wclk_s2_q;
    logic [CHANNELS-1:0] din_s1_q, din_s2_q;
    logic                bclk_rise;

    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            wclk_s1_q <= 1'b0;
            wclk_s2_q <= 1'b0;
            din_s1_q  <= '0;
            din_s2_q  <= '0;
        end else begin
            bclk_s1_q <= i2s_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            wclk_s1_q <= i2s_wclk;
            wclk_s2_q <= wclk_s1_q;
            din_s1_q  <= i2s_din;
            din_s2_q  <= din_s1_q;
        end
    end

    // wclk/din share the bclk synchroniser depth, so they are aligned with the rise.
    assign bclk_rise = bclk_s2_q & ~bclk_s3_q;

    // ---------------- capture ----------------
    logic [KW-1:0]    k_q, k_d;
    logic             wclk_prev_q, wclk_prev_d;
    logic             left_ok_q, left_ok_d;
    logic             right_done_q, right_done_d;
    logic             short_evt, latch;
    logic [WIDTH-1:0] shift_q [CHANNELS];
    logic [WIDTH-1:0] shift_d [CHANNELS];
    logic [WIDTH-1:0] left_sh_q [CHANNELS];
    logic [WIDTH-1:0] left_sh_d [CHANNELS];

    always_comb begin
        k_d          = k_q;
        wclk_prev_d  = wclk_prev_q;
        left_ok_d    = left_ok_q;
        right_done_d = 1'b0;
        short_evt    = 1'b0;
        shift_d      = shift_q;
        left_sh_d    = left_sh_q;
        if (latch) left_ok_d = 1'b0;
        if (bclk_rise) begin
            wclk_prev_d = wclk_s2_q;
            if (wclk_s2_q != wclk_prev_q) begin
                // New half: this rise is the I2S delay bit.
                k_d = '0;
                if (k_q != '0 && k_q < KFull) begin
                    short_evt = 1'b1;
                    left_ok_d = 1'b0;
                end
            end else if (k_q != KSat) begin
                k_d = k_q + KW'(1);
                if (k_d <= KFull) begin
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        shift_d[c] = {shift_q[c][WIDTH-2:0], din_s2_q[c]};
                    end
                end
                if (k_d == KFull) begin
                    if (!wclk_s2_q) begin
                        left_sh_d = shift_d;
                        left_ok_d = 1'b1;
                    end else begin
                        right_done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            k_q          <= KSat;
            wclk_prev_q  <= 1'b0;
            left_ok_q    <= 1'b0;
            right_done_q <= 1'b0;
            shift_q      <= '{default: '0};
            left_sh_q    <= '{default: '0};
        end else begin
            k_q          <= k_d;
            wclk_prev_q  <= wclk_prev_d;
            left_ok_q    <= left_ok_d;
            right_done_q <= right_done_d;
            shift_q      <= shift_d;
            left_sh_q    <= left_sh_d;
        end
    end

    // ---------------- frame latch and packer ----------------
    state_e           state_q, state_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]       hold_frame_q, hold_frame_d;
    logic [Slots-1:0] hold_en_q, hold_en_d;
    logic [WIDTH-1:0] hold_word_q [Slots];
    logic [WIDTH-1:0] hold_word_d [Slots];
    logic             push;
    logic [EntW-1:0]  push_data;

    // Right words are still in the shift registers: no rise can follow within one cycle.
    assign latch = right_done_q & left_ok_q;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_cnt_d  = frame_cnt_q;
        hold_frame_d = hold_frame_q;
        hold_en_d    = hold_en_q;
        hold_word_d  = hold_word_q;
        push         = 1'b0;
        push_data    = {hold_frame_q, 4'(slot_q), hold_word_q[slot_q]};
        case (state_q)
            StIdle: ;
            StPack: begin
                push = hold_en_q[slot_q];
                if (slot_q == LastSlot) state_d = StIdle;
                else                    slot_d  = slot_q + SlotW'(1);
            end
            default: state_d = StIdle;
        endcase
        if (latch) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                hold_word_d[2*c]   = left_sh_q[c];
                hold_word_d[2*c+1] = shift_q[c];
            end
            hold_en_d    = slot_en;
            hold_frame_d = frame_cnt_q;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            state_d      = StPack;
            slot_d       = '0;
        end
    end

    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            frame_cnt_q  <= '0;
            hold_frame_q <= '0;
            hold_en_q    <= '0;
            hold_word_q  <= '{default: '0};
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_cnt_q  <= frame_cnt_d;
            hold_frame_q <= hold_frame_d;
            hold_en_q    <= hold_en_d;
            hold_word_q  <= hold_word_d;
        end
    end

    // ---------------- word FIFO ----------------
    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] count_q, count_d;
    logic            full, pop, push_ok, drop;
    logic            overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [EntW-1:0] head;

    assign full    = (count_q == DepthLvl);
    assign pop     = out_valid & out_ready;
    // A pop frees the slot in the same cycle, so a push on full still lands.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LvlW'(1);
            2'b01:   count_d = count_q - LvlW'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = drop | (overflow_q & ~err_clr);
        frame_err_d = short_evt | (frame_err_q & ~err_clr);
    end

    always_ff @(posedge usbclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Outputs are forced to zero while empty so the unreset memory never leaks out.
    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? head[WIDTH-1:0] : '0;
    assign out_chan   = out_valid ? head[WIDTH+3:WIDTH] : '0;
    assign out_frame  = out_valid ? head[EntW-1:WIDTH+4] : '0;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/i2s_frame_packer.md
# i2s_frame_packer

Parametrised multi-line I2S capture and frame packer for the USB clock domain. It oversamples the shared BCLK/WCLK and up to CHANNELS stereo data lines, deserialises each half-frame into WIDTH-bit words, and latches a complete stereo frame. It then serialises the enabled words, tagged with frame ID and channel index, through a word FIFO to a valid/ready consumer (the USB stream engine). It replaces the single-channel, unbuffered sample hand-off with per-slot enable, buffering, and error reporting.

## Interface
- CHANNELS, 2, number of stereo I2S data lines (1..8)
- WIDTH, 24, captured bits per word, MSB-first (8..32)
- DEPTH, 16, FIFO depth in words, power of two ≥ 2*CHANNELS
- usbclk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i2s_bclk  in  1  I2S bit clock, asynchronous, ≤ usbclk/4
- i2s_wclk  in  1  I2S word clock, asynchronous; low = left
- i2s_din  in  CHANNELS  serial data lines, asynchronous
- slot_en  in  2*CHANNELS  slot enable; bit 2c = ch c left, bit 2c+1 = ch c right
- err_clr  in  1  one-cycle pulse clears overflow and frame_err
- out_data  out  WIDTH  sample word
- out_chan  out  4  slot index, 2c (left) or 2c+1 (right)
- out_frame  out  8  frame ID, wraps 255→0
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts
- fifo_level  out  $clog2(DEPTH)+1  words held
- overflow  out  1  sticky: word dropped because FIFO full
- frame_err  out  1  sticky: short half-frame seen

## Operation
- Sync: i2s_bclk, i2s_wclk, i2s_din each pass through 2-FF synchronisers. A BCLK rise is registered sync bclk 0→1; all capture logic acts only on that event.
- Bit counter k (per half-frame, shared across lines): at a BCLK rise where sampled wclk differs from the previous sampled wclk, set k=0 (delay bit, ignored) and record the half. At later rises, k increments and saturates at WIDTH+1. Rises with 1≤k≤WIDTH shift din[c] into shift register c.
- Left complete (k reaches WIDTH, wclk low): copy shift registers to left shadows; set left_ok.
- Right complete (k reaches WIDTH, wclk high): if left_ok, latch frame (left shadows + right shift regs + slot_en snapshot) into holding registers, start packer, clear left_ok. If left_ok=0 (first frame after reset or discarded left), drop silently. out_frame counter increments on every latched frame.
- Short half: wclk toggles while 1≤k<WIDTH → partial word discarded, left_ok cleared, frame_err set.
- Packer states: IDLE → PACK (slots 0..2*CHANNELS−1, one slot per cycle; enabled slot pushes {frame, slot, word}, disabled slot pushes nothing) → IDLE. A frame latch cannot occur during PACK at legal BCLK ratios.
- FIFO: show-ahead, DEPTH words. Push when full → word dropped, overflow set. Simultaneous push and pop when full → both proceed.
- err_clr: clears sticky flags. A simultaneous set event wins (flag stays 1).
- slot_en all zero → frames counted, nothing pushed.

## Timing
- Reset values: out_valid 0, out_data 0, out_chan 0, out_frame 0, fifo_level 0, overflow 0, frame_err 0, packer IDLE, left_ok 0, k=WIDTH+1.
- Input-to-event: BCLK rise seen 3 usbclk after pin edge (2 sync + edge reg).
- Frame latch 1 cycle after right-complete event. First push follows the latch cycle. out_valid rises the cycle after the first push.
- Handshake: transfer on out_valid & out_ready. out_data/out_chan/out_frame are stable while out_valid=1 and out_ready=0. Back-to-back pops give one word per cycle.
- fifo_level updates the cycle after push/pop.
- Reset asserted mid-frame or mid-pack: immediate clear, in-flight words lost. First emitted frame after release needs a full left then right half.

## Test plan
- CHANNELS=2, all slots enabled, BCLK=usbclk/8, 32 BCLK per half; ch0 L/R=0xA5A5A5/0x5A5A5A, ch1 0x123456/0xFEDCBA → words in slot order 0,1,2,3 with matching data, out_frame 0 then 1 on the next frame.
- slot_en=4'b1010, same stimulus → only slots 1 and 3 emitted per frame; out_frame increments by 1 per frame.
- out_ready=0 for 5 frames (20 words, DEPTH=16) → fifo_level 16, overflow=1; frames 0–3 intact on release; err_clr → overflow 0.
- WCLK toggles after 10 bits of a left half → frame_err=1, that frame not emitted, next full frame emitted with correct data.
- Reset released mid-right-half → no output until the next full L+R frame; first word has out_frame=0.
- Push and pop in the same cycle at fifo_level=DEPTH → no drop, level stays DEPTH, overflow stays 0.
